// File: rtl/ref_buffer_module.sv
// Reference Buffer: per-pointer-register banks of reference data with a 1-cycle
// valid/ready lookup port, bank invalidate, multi-cycle global flush and hit/miss counters.
module ref_buffer_module #(
  parameter int NUM_PTR   = 4,
  parameter int NUM_ENTRY = 16,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic                         ClockIn,
  input  logic                         AsyncResetIn,
  input  logic                         RB_WriteEn,
  input  logic                         RB_WriteValid,
  input  logic [$clog2(NUM_ENTRY)-1:0] RB_WriteIdx,
  input  logic [$clog2(NUM_PTR)-1:0]   RB_PtrRegId,
  input  logic [DATA_W-1:0]            RB_WriteData,
  input  logic                         FlushIn,
  input  logic                         RdReqIn,
  input  logic [$clog2(NUM_PTR)-1:0]   RdPtrRegIdIn,
  input  logic [$clog2(NUM_ENTRY)-1:0] RdIdxIn,
  output logic                         RdReadyOut,
  output logic                         RdValidOut,
  output logic                         RdHitOut,
  output logic [DATA_W-1:0]            RdDataOut,
  output logic                         FlushBusyOut,
  output logic [CNT_W-1:0]             HitCntOut,
  output logic [CNT_W-1:0]             MissCntOut
);

  localparam int PTR_W = $clog2(NUM_PTR);
  localparam int IDX_W = $clog2(NUM_ENTRY);
  localparam logic [PTR_W:0]   PTR_LIM  = (PTR_W+1)'(NUM_PTR);
  localparam logic [IDX_W:0]   IDX_LIM  = (IDX_W+1)'(NUM_ENTRY);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_PTR - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e                              stateR;
  state_e                              stateNextS;
  logic [PTR_W-1:0]                    bankR;
  logic [PTR_W-1:0]                    bankNextS;
  logic [NUM_PTR-1:0][NUM_ENTRY-1:0]   validR;
  logic [DATA_W-1:0]                   dataR [NUM_PTR][NUM_ENTRY];

  logic              readyR;
  logic              busyR;
  logic              rspValidR;
  logic              rspHitR;
  logic [DATA_W-1:0] rspDataR;
  logic [CNT_W-1:0]  hitCntR;
  logic [CNT_W-1:0]  missCntR;

  logic              wrPtrOkS;
  logic              wrIdxOkS;
  logic              rdPtrOkS;
  logic              rdIdxOkS;
  logic              wrAllowS;
  logic              wrEntryS;
  logic              wrInvS;
  logic              acceptS;
  logic              rdHitS;
  logic [DATA_W-1:0] rdDataS;

  // Range guards only bite when the bank/slot counts are not powers of two.
  assign wrPtrOkS = ({1'b0, RB_PtrRegId} < PTR_LIM);
  assign wrIdxOkS = ({1'b0, RB_WriteIdx} < IDX_LIM);
  assign rdPtrOkS = ({1'b0, RdPtrRegIdIn} < PTR_LIM);
  assign rdIdxOkS = ({1'b0, RdIdxIn} < IDX_LIM);

  // A flush request in the same idle cycle wins over the write.
  assign wrAllowS = RB_WriteEn & (stateR == ST_IDLE) & ~FlushIn & wrPtrOkS;
  assign wrEntryS = wrAllowS & RB_WriteValid & wrIdxOkS;
  assign wrInvS   = wrAllowS & ~RB_WriteValid;
  assign acceptS  = RdReqIn & readyR;

  // Lookup result, bypassing a same-cycle write or bank invalidate.
  always_comb begin
    rdHitS  = 1'b0;
    rdDataS = '0;
    if (rdPtrOkS && rdIdxOkS) begin
      if (wrEntryS && (RB_PtrRegId == RdPtrRegIdIn) && (RB_WriteIdx == RdIdxIn)) begin
        rdHitS  = 1'b1;
        rdDataS = RB_WriteData;
      end else if (wrInvS && (RB_PtrRegId == RdPtrRegIdIn)) begin
        rdHitS  = 1'b0;
        rdDataS = '0;
      end else if (validR[RdPtrRegIdIn][RdIdxIn]) begin
        rdHitS  = 1'b1;
        rdDataS = dataR[RdPtrRegIdIn][RdIdxIn];
      end else begin
        rdHitS  = 1'b0;
        rdDataS = '0;
      end
    end else begin
      rdHitS  = 1'b0;
      rdDataS = '0;
    end
  end

  // Next-state logic for the idle/flush controller.
  always_comb begin
    stateNextS = stateR;
    bankNextS  = bankR;
    case (stateR)
      ST_IDLE: begin
        if (FlushIn) begin
          stateNextS = ST_FLUSH;
          bankNextS  = '0;
        end else begin
          stateNextS = ST_IDLE;
          bankNextS  = bankR;
        end
      end
      ST_FLUSH: begin
        if (bankR == PTR_LAST) begin
          stateNextS = ST_IDLE;
          bankNextS  = '0;
        end else begin
          stateNextS = ST_FLUSH;
          bankNextS  = bankR + PTR_W'(1);
        end
      end
      default: begin
        stateNextS = ST_IDLE;
        bankNextS  = '0;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge ClockIn or negedge AsyncResetIn) begin
    if (!AsyncResetIn) begin
      stateR <= ST_IDLE;
      bankR  <= '0;
    end else begin
      stateR <= stateNextS;
      bankR  <= bankNextS;
    end
  end

  // Valid bits: flush clears one bank per cycle, writes set or invalidate.
  always_ff @(posedge ClockIn or negedge AsyncResetIn) begin
    if (!AsyncResetIn) begin
      validR <= '0;
    end else if (stateR == ST_FLUSH) begin
      validR[bankR] <= '0;
    end else if (wrEntryS) begin
      validR[RB_PtrRegId][RB_WriteIdx] <= 1'b1;
    end else if (wrInvS) begin
      validR[RB_PtrRegId] <= '0;
    end else begin
      validR <= validR;
    end
  end

  // Entry data storage; invalidation leaves data untouched.
  always_ff @(posedge ClockIn or negedge AsyncResetIn) begin
    if (!AsyncResetIn) begin
      for (int b = 0; b < NUM_PTR; b++) begin
        for (int e = 0; e < NUM_ENTRY; e++) begin
          dataR[b][e] <= '0;
        end
      end
    end else if (wrEntryS) begin
      dataR[RB_PtrRegId][RB_WriteIdx] <= RB_WriteData;
    end else begin
      dataR <= dataR;
    end
  end

  // Registered handshake, status and response outputs.
  always_ff @(posedge ClockIn or negedge AsyncResetIn) begin
    if (!AsyncResetIn) begin
      readyR    <= 1'b0;
      busyR     <= 1'b0;
      rspValidR <= 1'b0;
      rspHitR   <= 1'b0;
      rspDataR  <= '0;
    end else begin
      readyR    <= (stateNextS == ST_IDLE);
      busyR     <= (stateNextS == ST_FLUSH);
      rspValidR <= acceptS;
      rspHitR   <= acceptS & rdHitS;
      rspDataR  <= acceptS ? rdDataS : '0;
    end
  end

  // Saturating performance counters, one step per response.
  always_ff @(posedge ClockIn or negedge AsyncResetIn) begin
    if (!AsyncResetIn) begin
      hitCntR  <= '0;
      missCntR <= '0;
    end else if (acceptS && rdHitS) begin
      hitCntR  <= (hitCntR == '1) ? hitCntR : hitCntR + CNT_W'(1);
    end else if (acceptS) begin
      missCntR <= (missCntR == '1) ? missCntR : missCntR + CNT_W'(1);
    end else begin
      hitCntR  <= hitCntR;
      missCntR <= missCntR;
    end
  end

  assign RdReadyOut   = readyR;
  assign FlushBusyOut = busyR;
  assign RdValidOut   = rspValidR;
  assign RdHitOut     = rspHitR;
  assign RdDataOut    = rspDataR;
  assign HitCntOut    = hitCntR;
  assign MissCntOut   = missCntR;

endmodule

// File: tb/tb_ref_buffer_module.sv
// Self-checking bench for ref_buffer_module: a behavioural model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_ref_buffer_module;

  logic        ClockIn = 1'b0;
  logic        AsyncResetIn = 1'b0;
  logic        RB_WriteEn = 1'b0;
  logic        RB_WriteValid = 1'b0;
  logic [3:0]  RB_WriteIdx = 4'd0;
  logic [1:0]  RB_PtrRegId = 2'd0;
  logic [31:0] RB_WriteData = 32'd0;
  logic        FlushIn = 1'b0;
  logic        RdReqIn = 1'b0;
  logic [1:0]  RdPtrRegIdIn = 2'd0;
  logic [3:0]  RdIdxIn = 4'd0;
  logic        RdReadyOut, RdValidOut, RdHitOut, FlushBusyOut;
  logic [31:0] RdDataOut;
  logic [15:0] HitCntOut, MissCntOut;

  int compared = 0;
  int mismatched = 0;

  ref_buffer_module dut (
    .ClockIn(ClockIn), .AsyncResetIn(AsyncResetIn),
    .RB_WriteEn(RB_WriteEn), .RB_WriteValid(RB_WriteValid), .RB_WriteIdx(RB_WriteIdx),
    .RB_PtrRegId(RB_PtrRegId), .RB_WriteData(RB_WriteData), .FlushIn(FlushIn),
    .RdReqIn(RdReqIn), .RdPtrRegIdIn(RdPtrRegIdIn), .RdIdxIn(RdIdxIn),
    .RdReadyOut(RdReadyOut), .RdValidOut(RdValidOut), .RdHitOut(RdHitOut),
    .RdDataOut(RdDataOut), .FlushBusyOut(FlushBusyOut),
    .HitCntOut(HitCntOut), .MissCntOut(MissCntOut)
  );

  always #5 ClockIn = ~ClockIn;

  // Behavioural model: storage as plain arrays, flush as a countdown of remaining banks.
  bit          mValid [4][16];
  logic [31:0] mData  [4][16];
  int          mBusyLeft = 0;
  bit          mReady = 1'b0;
  bit          mRspValid = 1'b0;
  bit          mRspHit = 1'b0;
  logic [31:0] mRspData = 32'd0;
  int          mHits = 0;
  int          mMisses = 0;

  always @(posedge ClockIn or negedge AsyncResetIn) begin
    if (!AsyncResetIn) begin
      foreach (mValid[p, i]) begin mValid[p][i] = 1'b0; mData[p][i] = 32'd0; end
      mBusyLeft = 0; mReady = 1'b0; mRspValid = 1'b0; mRspHit = 1'b0; mRspData = 32'd0;
      mHits = 0; mMisses = 0;
    end else begin
      bit acc;
      acc = RdReqIn && mReady;
      // Writes land first (if the buffer is idle and no flush is requested), so the lookup sees them.
      if (RB_WriteEn && mBusyLeft == 0 && !FlushIn) begin
        if (RB_WriteValid) begin
          mValid[RB_PtrRegId][RB_WriteIdx] = 1'b1;
          mData[RB_PtrRegId][RB_WriteIdx]  = RB_WriteData;
        end else begin
          for (int i = 0; i < 16; i++) mValid[RB_PtrRegId][i] = 1'b0;
        end
      end
      mRspValid = acc;
      mRspHit   = acc && mValid[RdPtrRegIdIn][RdIdxIn];
      mRspData  = mRspHit ? mData[RdPtrRegIdIn][RdIdxIn] : 32'd0;
      if (acc && mRspHit && mHits < 65535) mHits++;
      if (acc && !mRspHit && mMisses < 65535) mMisses++;
      if (mBusyLeft > 0) begin
        for (int i = 0; i < 16; i++) mValid[4 - mBusyLeft][i] = 1'b0;
        mBusyLeft--;
      end else if (FlushIn) begin
        mBusyLeft = 4;
      end
      mReady = (mBusyLeft == 0);
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge ClockIn) begin
    cmp("ready", 32'(RdReadyOut), 32'(mReady));
    cmp("busy", 32'(FlushBusyOut), 32'(mBusyLeft > 0));
    cmp("rvalid", 32'(RdValidOut), 32'(mRspValid));
    cmp("rhit", 32'(RdHitOut), 32'(mRspHit));
    cmp("rdata", RdDataOut, mRspData);
    cmp("hitcnt", 32'(HitCntOut), 32'(mHits));
    cmp("misscnt", 32'(MissCntOut), 32'(mMisses));
  end

  task automatic step();
    @(posedge ClockIn);
    #2;
    RB_WriteEn = 1'b0; FlushIn = 1'b0; RdReqIn = 1'b0;
  endtask

  task automatic setWr(input int p, input int i, input logic [31:0] d);
    RB_WriteEn = 1'b1; RB_WriteValid = 1'b1; RB_PtrRegId = 2'(p); RB_WriteIdx = 4'(i); RB_WriteData = d;
  endtask

  task automatic setRd(input int p, input int i);
    RdReqIn = 1'b1; RdPtrRegIdIn = 2'(p); RdIdxIn = 4'(i);
  endtask

  task automatic wr(input int p, input int i, input logic [31:0] d);
    setWr(p, i, d); step();
  endtask

  task automatic rd(input int p, input int i);
    setRd(p, i); step();
  endtask

  initial begin
    #23;
    cmp("lit_reset_ready", 32'(RdReadyOut), 32'd0);
    cmp("lit_reset_cnt", 32'(MissCntOut), 32'd0);
    AsyncResetIn = 1'b1;
    step(); step();

    // T1: lookup on empty buffer misses
    rd(2, 5);
    cmp("lit_t1_valid", 32'(RdValidOut), 32'd1);
    cmp("lit_t1_hit", 32'(RdHitOut), 32'd0);
    cmp("lit_t1_data", RdDataOut, 32'd0);
    cmp("lit_t1_miss", 32'(MissCntOut), 32'd1);
    step();
    cmp("lit_t1_pulse", 32'(RdValidOut), 32'd0);

    // T2: write then lookup
    wr(1, 3, 32'hDEADBEEF);
    rd(1, 3);
    cmp("lit_t2_hit", 32'(RdHitOut), 32'd1);
    cmp("lit_t2_data", RdDataOut, 32'hDEADBEEF);
    cmp("lit_t2_hitcnt", 32'(HitCntOut), 32'd1);

    // T3: same-cycle write and lookup bypass
    setWr(0, 7, 32'h1234); setRd(0, 7); step();
    cmp("lit_t3_hit", 32'(RdHitOut), 32'd1);
    cmp("lit_t3_data", RdDataOut, 32'h1234);

    // T4: fill ptr3, invalidate it, ptr0 survives; also invalidate bypass
    for (int i = 0; i < 16; i++) wr(3, i, 32'h300 + 32'(i));
    rd(3, 9);
    cmp("lit_t4_prefill", RdDataOut, 32'h309);
    RB_WriteEn = 1'b1; RB_WriteValid = 1'b0; RB_PtrRegId = 2'd3; step();
    for (int i = 0; i < 16; i++) begin
      rd(3, i);
      cmp("lit_t4_inv_miss", 32'(RdHitOut), 32'd0);
    end
    rd(0, 7);
    cmp("lit_t4_ptr0", RdDataOut, 32'h1234);
    wr(3, 0, 32'hABCD);
    RB_WriteEn = 1'b1; RB_WriteValid = 1'b0; RB_PtrRegId = 2'd3; setRd(3, 0); step();
    cmp("lit_t4_invbypass", 32'(RdHitOut), 32'd0);
    cmp("lit_t4_misscnt", 32'(MissCntOut), 32'd18);

    // T5: flush (with a same-cycle write that must be dropped)
    setWr(0, 2, 32'h55); FlushIn = 1'b1; step();
    for (int k = 0; k < 4; k++) begin
      cmp("lit_t5_busy", 32'(FlushBusyOut), 32'd1);
      cmp("lit_t5_ready", 32'(RdReadyOut), 32'd0);
      if (k == 1) setWr(1, 4, 32'h77);
      if (k == 2) begin setRd(1, 3); FlushIn = 1'b1; end
      step();
      if (k == 2) cmp("lit_t5_noaccept", 32'(RdValidOut), 32'd0);
    end
    cmp("lit_t5_done_busy", 32'(FlushBusyOut), 32'd0);
    cmp("lit_t5_done_ready", 32'(RdReadyOut), 32'd1);
    rd(0, 2); cmp("lit_t5_flushwr_drop", 32'(RdHitOut), 32'd0);
    rd(1, 4); cmp("lit_t5_busywr_drop", 32'(RdHitOut), 32'd0);
    rd(1, 3); cmp("lit_t5_cleared", 32'(RdHitOut), 32'd0);
    rd(0, 7); cmp("lit_t5_cleared0", 32'(RdHitOut), 32'd0);

    // T6: miss counter saturation, then reset in the middle of a flush
    for (int n = 0; n < 65535; n++) rd(2, 0);
    cmp("lit_t6_sat", 32'(MissCntOut), 32'h0000FFFF);
    rd(2, 1);
    cmp("lit_t6_stay", 32'(MissCntOut), 32'h0000FFFF);
    FlushIn = 1'b1; step(); step();
    cmp("lit_t6_midflush", 32'(FlushBusyOut), 32'd1);
    setRd(0, 0);
    AsyncResetIn = 1'b0;
    #1;
    cmp("lit_t6_rst_busy", 32'(FlushBusyOut), 32'd0);
    cmp("lit_t6_rst_miss", 32'(MissCntOut), 32'd0);
    cmp("lit_t6_rst_hit", 32'(HitCntOut), 32'd0);
    step();
    AsyncResetIn = 1'b1;
    step();
    cmp("lit_t6_after_ready", 32'(RdReadyOut), 32'd1);
    cmp("lit_t6_after_valid", 32'(RdValidOut), 32'd0);
    rd(1, 3);
    cmp("lit_t6_after_miss", 32'(MissCntOut), 32'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
